// File: rtl/button_event_pkg.sv
// Shared event codes, per-button FSM state encoding and slot helper
// for the button event scheduler.
package button_event_pkg;

    localparam int CNT_W = 28;

    typedef enum logic [1:0] {
        KIND_PRESS   = 2'b00,
        KIND_REPEAT  = 2'b01,
        KIND_RELEASE = 2'b10
    } event_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_HOLD_INITIAL = 2'b01,
        ST_HOLD_REPEAT  = 2'b10
    } btn_state_e;

    // A release may replace a queued repeat: the repeat is stale once the button is up.
    function automatic logic releaseOverrides(event_kind_e pending, event_kind_e incoming);
        return (incoming == KIND_RELEASE) && (pending == KIND_REPEAT);
    endfunction

endpackage

// File: rtl/button_repeater.sv
// One button: press/hold/repeat FSM with its cycle counter and a
// one-entry pending event slot drained by the top-level arbiter.
module button_repeater
    import button_event_pkg::*;
#(
    parameter logic [CNT_W-1:0] INITIAL_DELAY = 28'd74250000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = 28'd14850000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        active_i,
    input  logic        drain_i,
    output logic        full_o,
    output event_kind_e kind_o,
    output logic        drop_o
);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             slotFull_q, slotFull_d;
    event_kind_e      slotKind_q, slotKind_d;
    logic             drop_q, drop_d;
    logic             raise;
    event_kind_e      raiseKind;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        raise     = 1'b0;
        raiseKind = KIND_PRESS;
        if (!enable_i) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (active_i) begin
                        raise     = 1'b1;
                        raiseKind = KIND_PRESS;
                        count_d   = '0;
                        state_d   = ST_HOLD_INITIAL;
                    end
                end
                ST_HOLD_INITIAL: begin
                    if (!active_i) begin
                        raise     = 1'b1;
                        raiseKind = KIND_RELEASE;
                        count_d   = '0;
                        state_d   = ST_IDLE;
                    end else if (count_q == INITIAL_DELAY) begin
                        raise     = 1'b1;
                        raiseKind = KIND_REPEAT;
                        count_d   = '0;
                        state_d   = ST_HOLD_REPEAT;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                ST_HOLD_REPEAT: begin
                    if (!active_i) begin
                        raise     = 1'b1;
                        raiseKind = KIND_RELEASE;
                        count_d   = '0;
                        state_d   = ST_IDLE;
                    end else if (count_q == REPEAT_PERIOD) begin
                        raise     = 1'b1;
                        raiseKind = KIND_REPEAT;
                        count_d   = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // A slot emptied by the arbiter on this edge counts as free for a new event.
    always_comb begin
        slotFull_d = slotFull_q;
        slotKind_d = slotKind_q;
        drop_d     = 1'b0;
        if (drain_i) begin
            slotFull_d = 1'b0;
        end
        if (raise) begin
            if (!slotFull_q || drain_i) begin
                slotFull_d = 1'b1;
                slotKind_d = raiseKind;
            end else if (releaseOverrides(slotKind_q, raiseKind)) begin
                slotKind_d = raiseKind;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            slotFull_q <= 1'b0;
            slotKind_q <= KIND_PRESS;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            slotFull_q <= slotFull_d;
            slotKind_q <= slotKind_d;
            drop_q     <= drop_d;
        end
    end

    assign full_o = slotFull_q;
    assign kind_o = slotKind_q;
    assign drop_o = drop_q;

endmodule

// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into PRESS/REPEAT/RELEASE events, arbitrated
// round-robin into a single registered valid/ready output stage.
module button_event_scheduler
    import button_event_pkg::*;
#(
    parameter int               N_BUTTONS     = 4,
    parameter logic             ACTIVE_LEVEL  = 1'b1,
    parameter logic [CNT_W-1:0] INITIAL_DELAY = 28'd74250000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = 28'd14850000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_BUTTONS-1:0]         buttons,
    input  logic                         enable,
    output logic                         event_valid,
    input  logic                         event_ready,
    output logic [$clog2(N_BUTTONS)-1:0] event_id,
    output logic [1:0]                   event_kind,
    output logic                         dropped
);

    localparam int ID_W = $clog2(N_BUTTONS);

    logic [N_BUTTONS-1:0] slotFull;
    event_kind_e          slotKind [N_BUTTONS];
    logic [N_BUTTONS-1:0] drain;
    logic [N_BUTTONS-1:0] dropVec;

    logic                 outValid_q, outValid_d;
    logic [ID_W-1:0]      outId_q, outId_d;
    event_kind_e          outKind_q, outKind_d;
    logic [ID_W-1:0]      rrPtr_q, rrPtr_d;
    logic                 found;
    int                   cand;
    logic [ID_W-1:0]      candIdx;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        button_repeater #(
            .INITIAL_DELAY (INITIAL_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_repeater (
            .clock    (clock),
            .reset    (reset),
            .enable_i (enable),
            .active_i (buttons[g] == ACTIVE_LEVEL),
            .drain_i  (drain[g]),
            .full_o   (slotFull[g]),
            .kind_o   (slotKind[g]),
            .drop_o   (dropVec[g])
        );
    end

    // Search starts one past the last grant so every button gets a turn.
    always_comb begin
        outValid_d = outValid_q;
        outId_d    = outId_q;
        outKind_d  = outKind_q;
        rrPtr_d    = rrPtr_q;
        drain      = '0;
        found      = 1'b0;
        cand       = 0;
        candIdx    = '0;
        if (!outValid_q || event_ready) begin
            outValid_d = 1'b0;
            for (int off = 1; off <= N_BUTTONS; off++) begin
                cand = int'(rrPtr_q) + off;
                if (cand >= N_BUTTONS) begin
                    cand = cand - N_BUTTONS;
                end
                candIdx = ID_W'(cand);
                if (!found && slotFull[candIdx]) begin
                    found          = 1'b1;
                    outValid_d     = 1'b1;
                    outId_d        = candIdx;
                    outKind_d      = slotKind[candIdx];
                    drain[candIdx] = 1'b1;
                    rrPtr_d        = candIdx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outId_q    <= '0;
            outKind_q  <= KIND_PRESS;
            rrPtr_q    <= ID_W'(N_BUTTONS - 1);
        end else begin
            outValid_q <= outValid_d;
            outId_q    <= outId_d;
            outKind_q  <= outKind_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

    assign event_valid = outValid_q;
    assign event_id    = outId_q;
    assign event_kind  = outKind_q;
    assign dropped     = |dropVec;

endmodule

// File: doc/button_event_scheduler.md
BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

Interface
REQ-001 Parameter N_BUTTONS SHALL default to 4; it is the number of debounced button inputs (2..8).
REQ-002 Parameter ACTIVE_LEVEL SHALL default to 1'b1; it is the input level meaning "pressed".
REQ-003 Parameter INITIAL_DELAY SHALL default to 28'd74250000; it is the hold cycles before the first repeat (0.5 s at 148.5 MHz).
REQ-004 Parameter REPEAT_PERIOD SHALL default to 28'd14850000; it is the cycles between repeats (0.1 s).
REQ-005 clock  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 buttons  input  N_BUTTONS  already-debounced button levels.
REQ-008 enable  input  1  high = event generation armed.
REQ-009 event_valid  output  1  an event is presented.
REQ-010 event_ready  input  1  consumer accepts the event on a cycle with event_valid high.
REQ-011 event_id  output  clog2(N_BUTTONS)  index of the button that produced the event.
REQ-012 event_kind  output  2  event type: 2'b00 PRESS, 2'b01 REPEAT, 2'b10 RELEASE (2'b11 unused).
REQ-013 dropped  output  1  one-cycle pulse when any event is discarded.

Function
REQ-014 Each button SHALL run an FSM with states IDLE, HOLD_INITIAL and HOLD_REPEAT, plus a 28-bit counter.
REQ-015 IDLE, button active: raise PRESS, clear the counter, go to HOLD_INITIAL.
REQ-016 HOLD_INITIAL or HOLD_REPEAT, button inactive: raise RELEASE and go to IDLE; release takes priority over the counter limit in the same cycle.
REQ-017 HOLD_INITIAL, counter == INITIAL_DELAY: raise REPEAT, clear the counter, go to HOLD_REPEAT; otherwise increment the counter.
REQ-018 HOLD_REPEAT, counter == REPEAT_PERIOD: raise REPEAT and clear the counter; otherwise increment the counter.
REQ-019 Each button SHALL own a one-entry pending slot holding an event kind.
REQ-020 A raised event SHALL be written to the slot on the same edge that samples the button change.
REQ-021 Slot full and new RELEASE with a pending REPEAT: the RELEASE SHALL overwrite the slot, with no dropped pulse.
REQ-022 Slot full in any other case: the new event SHALL be discarded and dropped SHALL pulse on the next cycle.
REQ-023 Slot drained on the same edge a new event arrives: the new event SHALL be stored, not dropped.
REQ-024 A registered output stage SHALL present one event at a time; when empty, or on a valid&&ready edge, it SHALL load the round-robin winner among full slots and clear that slot.
REQ-025 Round-robin search SHALL start at (last granted id + 1) mod N_BUTTONS.
REQ-026 event_id and event_kind SHALL hold stable while event_valid is high and event_ready is low.
REQ-027 Minimum latency SHALL be button change sampled at edge k -> event_valid high after edge k+1.
REQ-028 Sustained throughput SHALL be one event per cycle when event_ready is held high.
REQ-029 enable low: FSMs forced to IDLE, counters cleared, no new events raised.
REQ-030 enable low: pending slots and the output stage SHALL still drain normally.
REQ-031 enable rising with a button held SHALL produce a PRESS for that button.

Reset
REQ-032 On reset: event_valid, event_id, event_kind and dropped SHALL be 0; FSMs IDLE; counters 0; slots empty.
REQ-033 On reset the round-robin pointer SHALL be N_BUTTONS-1, so button 0 wins first.
REQ-034 Reset asserted mid-hold or with an event presented SHALL abandon the event without a dropped pulse.

Structure
REQ-035 A shared package button_event_pkg SHALL hold the event_kind codes and the FSM state encoding.
REQ-036 Per-button FSM, counter and pending slot SHALL live in one sub-module, button_repeater, instantiated N_BUTTONS times.
REQ-037 Arbiter and output stage SHALL live in the top module.

Verification (bench parameters: N_BUTTONS=4, INITIAL_DELAY=10, REPEAT_PERIOD=4, event_ready=1 unless stated)
REQ-038 Press button 2 for 3 cycles -> PRESS id 2, then RELEASE id 2; no REPEAT; dropped never high.
REQ-039 Hold button 0 for 30 cycles -> PRESS; REPEATs at 11, 16, 21 and 26 cycles after PRESS; then RELEASE.
REQ-040 Buttons 0-3 pressed in the same cycle -> PRESS ids 0, 1, 2, 3 on consecutive cycles, one per cycle.
REQ-041 event_ready low 40 cycles while button 1 held -> REPEAT dropped (dropped pulses); on release the RELEASE replaces the pending REPEAT; delivered order PRESS, RELEASE.
REQ-042 Reset at HOLD_REPEAT mid-count with event_valid high -> next cycle all outputs 0; a still-held button yields a fresh PRESS.
REQ-043 enable low during a hold -> no REPEAT and no RELEASE raised; enable high with the button held -> PRESS within 2 cycles.
